mem_port_arbiter: RTL

Shares the processor's single memory port between two requesters: the processor core data path and the serial command processor acting as host. It replaces the hard override on the external memory control lines with a request/acknowledge arbiter. The host gets bounded priority, and the core is stalled while it waits. It sits between Processor/SerialCommandProcessor and the memory, and runs on the memory clock.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/arb_winner_select.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Memory access mode encodings shared with the processor, plus the
// state and owner types used by the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ReadWriteMode_NONE          = 3'd0,
    ReadWriteMode_BYTE          = 3'd1,
    ReadWriteMode_HALF          = 3'd2,
    ReadWriteMode_WORD          = 3'd3,
    ReadWriteMode_BYTE_UNSIGNED = 3'd4,
    ReadWriteMode_HALF_UNSIGNED = 3'd5
  } ReadWriteModes;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_HOST = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/arb_winner_select.sv
// Combinational grant decision for the memory port arbiter.
// Default is bounded host priority; ARB_ROUND_ROBIN_EN selects alternating grants.
import mem_port_arbiter_pkg::*;

module arb_winner_select #(
  parameter int HOST_BURST_MAX = 4
) (
  input  logic       coreReq,
  input  logic       hostReq,
  input  logic [3:0] streak,
  input  logic [1:0] lastOwner,
  output logic [1:0] winner
);

`ifdef ARB_ROUND_ROBIN_EN
  logic unusedStreak;
  assign unusedStreak = ^streak;

  // On contention the requester not served last goes next; after reset lastOwner is NONE, so host first.
  always_comb begin
    winner = OWNER_NONE;
    if (hostReq && coreReq) begin
      winner = (lastOwner == OWNER_HOST) ? OWNER_CORE : OWNER_HOST;
    end else if (hostReq) begin
      winner = OWNER_HOST;
    end else if (coreReq) begin
      winner = OWNER_CORE;
    end
  end
`else
  localparam logic [3:0] BurstMax = 4'(HOST_BURST_MAX);

  logic unusedLastOwner;
  assign unusedLastOwner = ^lastOwner;

  // Host wins until it has taken BurstMax grants in a row while the core waits.
  always_comb begin
    winner = OWNER_NONE;
    if (hostReq && !(coreReq && (streak == BurstMax))) begin
      winner = OWNER_HOST;
    end else if (coreReq) begin
      winner = OWNER_CORE;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/acknowledge arbiter sharing the memory port between core and host; ack READ_LATENCY+2 cycles after grant.
// Core is stalled until its ack; define ARB_ROUND_ROBIN_EN for alternating grants instead of bounded host priority.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int READ_LATENCY   = 1,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_read_mode,
  input  logic [2:0]  core_write_mode,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  output logic        core_stall,
  input  logic        host_req,
  input  logic        host_write,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_read_mode,
  output logic [2:0]  mem_write_mode,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LastWait = 3'(READ_LATENCY - 1);
  localparam logic [3:0] BurstMax = 4'(HOST_BURST_MAX);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t lastOwner;
  logic [3:0] streak;
  logic [2:0] waitCnt;
  logic [2:0] regReadMode;
  logic [2:0] regWriteMode;
  logic [1:0] winner;
  logic [2:0] coreEffReadMode;

  arb_winner_select #(
    .HOST_BURST_MAX(HOST_BURST_MAX)
  ) uWinnerSelect (
    .coreReq   (core_req),
    .hostReq   (host_req),
    .streak    (streak),
    .lastOwner (lastOwner),
    .winner    (winner)
  );

  // A core request carrying both modes performs only the write.
  assign coreEffReadMode = (core_write_mode != ReadWriteMode_NONE) ? ReadWriteMode_NONE : core_read_mode;

  assign mem_read_mode  = (state == ISSUE) ? regReadMode  : ReadWriteMode_NONE;
  assign mem_write_mode = (state == ISSUE) ? regWriteMode : ReadWriteMode_NONE;
  assign core_stall     = core_req & ~core_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= OWNER_NONE;
      lastOwner    <= OWNER_NONE;
      streak       <= '0;
      waitCnt      <= '0;
      regReadMode  <= ReadWriteMode_NONE;
      regWriteMode <= ReadWriteMode_NONE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rdata   <= '0;
      host_rdata   <= '0;
      core_ack     <= 1'b0;
      host_ack     <= 1'b0;
    end else begin
      core_ack <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!host_req) begin
            streak <= '0;
          end
          if (winner == OWNER_HOST) begin
            streak       <= (streak == BurstMax) ? streak : streak + 4'd1;
            mem_addr     <= host_addr;
            mem_wdata    <= host_wdata;
            regWriteMode <= host_write ? ReadWriteMode_WORD : ReadWriteMode_NONE;
            regReadMode  <= host_write ? ReadWriteMode_NONE : ReadWriteMode_WORD;
            owner        <= OWNER_HOST;
            lastOwner    <= OWNER_HOST;
            state        <= ISSUE;
          end else if (winner == OWNER_CORE) begin
            streak       <= '0;
            mem_addr     <= core_addr;
            mem_wdata    <= core_wdata;
            regWriteMode <= core_write_mode;
            regReadMode  <= coreEffReadMode;
            owner        <= OWNER_CORE;
            lastOwner    <= OWNER_CORE;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == LastWait) begin
            // Data is valid in the last WAIT cycle; the ack cycle presents it registered.
            if (owner == OWNER_HOST) begin
              host_rdata <= mem_rdata;
              host_ack   <= 1'b1;
            end else if (owner == OWNER_CORE) begin
              core_rdata <= (regReadMode == ReadWriteMode_NONE) ? 32'd0 : mem_rdata;
              core_ack   <= 1'b1;
            end
            state <= ACK;
          end else begin
            waitCnt <= waitCnt + 3'd1;
          end
        end
        ACK: begin
          owner <= OWNER_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
